pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the Samba fetch stage: holds the PC register, computes the sequential next address, and selects among sequential, branch and jump targets under stall and halt control. It generalises the fixed 9-bit +1 incrementer to configurable width and step, and adds the registered PC, redirect priority, a post-redirect flush pulse, a halt state and a saturating fetch counter. It drives the instruction-memory address and the IF/ID pipeline register.

## Interface
Parameters:
- PC_WIDTH, 9, PC and target width in bits
- PC_STEP, 1, sequential increment (addressing unit per instruction)
- RESET_PC, 0, PC value loaded on reset
- CNT_WIDTH, 16, width of fetch counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold PC (hazard unit)
- branch_i  in  1  branch taken, redirect to branch_target_i
- branch_target_i  in  PC_WIDTH  branch destination
- jump_i  in  1  jump, redirect to jump_target_i
- jump_target_i  in  PC_WIDTH  jump destination
- halt_i  in  1  enter HALTED state
- pc_o  out  PC_WIDTH  current PC (registered)
- pc_next_o  out  PC_WIDTH  pc_o + PC_STEP (combinational, for link/branch base)
- valid_o  out  1  pc_o is a fetch to be executed
- flush_o  out  1  one-cycle pulse after redirect; IF/ID must discard
- halted_o  out  1  unit is in HALTED
- fetch_cnt_o  out  CNT_WIDTH  number of sequential+redirect PC advances, saturating

## Operation
- States: RUN, HALTED. Reset -> RUN.
- Reset values: pc_o=RESET_PC, valid_o=0, flush_o=0, halted_o=0, fetch_cnt_o=0; valid_o rises in the first cycle after reset deasserts.
- Per-cycle priority in RUN: reset > halt_i > jump_i > branch_i > stall_i > sequential.
  - halt_i: go HALTED, PC frozen, valid_o=0.
  - jump_i: pc <= jump_target_i, flush_o<=1, count++.
  - branch_i: pc <= branch_target_i, flush_o<=1, count++.
  - stall_i: pc, count unchanged; flush_o<=0.
  - else: pc <= pc_o + PC_STEP, count++.
- Redirect overrides stall (redirect comes from a later stage).
- HALTED: all inputs except reset ignored; pc_o frozen, valid_o=0, halted_o=1, flush_o=0. Exit only via reset.
- Arithmetic: pc_o + PC_STEP taken modulo 2^PC_WIDTH; max PC wraps to (PC_STEP-1). Targets used as given, no alignment check.
- fetch_cnt_o saturates at 2^CNT_WIDTH-1, never wraps.

## Timing
- PC update latency 1 cycle: control sampled at edge t, new pc_o visible after edge t.
- pc_next_o tracks pc_o combinationally, zero latency.
- flush_o is registered: high exactly the one cycle in which pc_o first shows the redirect target; back-to-back redirects give flush_o high on consecutive cycles.
- halted_o and valid_o=0 take effect the cycle after halt_i is sampled.
- Reset mid-operation (including HALTED or during flush) restores all reset values at the next edge; in-flight redirect discarded.
- No combinational path from any input to pc_o, valid_o, flush_o, halted_o.

## Structure
- Shared package (samba_pkg): state encoding (RUN, HALTED), default PC_WIDTH and RESET_PC constants used by fetch and memory blocks.
- One sub-module: pc_adder (parametrised PC_WIDTH, PC_STEP, purely combinational, wrapping add) instantiated for pc_next_o; next-PC mux, FSM and counter in pc_unit.

## Test plan
- Reset then 5 free-running cycles, PC_WIDTH=9, STEP=1 -> pc_o 0,1,2,3,4, valid_o=1 after first cycle, fetch_cnt_o=5.
- pc_o=10, stall_i for 3 cycles -> pc_o stays 10, count constant; stall released -> 11.
- pc_o=20, stall_i=1 and branch_i=1 target 100 same cycle -> pc_o=100, flush_o=1 one cycle; jump_i=1 target 7 with branch_i target 50 -> pc_o=7 (jump wins).
- PC_WIDTH=9, pc_o=511, sequential -> pc_o=0; CNT_WIDTH=2, 6 advances -> fetch_cnt_o=3.
- halt_i at pc_o=42 -> halted_o=1, valid_o=0, pc_o=42 held despite jump_i/branch_i; reset -> pc_o=RESET_PC, halted_o=0.
- Reset asserted the cycle flush_o=1 -> next cycle flush_o=0, pc_o=RESET_PC, fetch_cnt_o=0.

Source files
------------

// File: rtl/samba_pkg.sv
// Shared fetch/memory definitions for the Samba core.
package samba_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  localparam int unsigned DEFAULT_PC_WIDTH = 9;
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/pc_adder.sv
// Sequential-address adder: pc + STEP, wrapping modulo 2^PC_WIDTH.
module pc_adder #(
  parameter int unsigned PC_WIDTH = 9,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] sum
);

  // Carry out of the top bit is dropped, giving the wrap-around.
  always_comb begin
    sum = pc + PC_WIDTH'(PC_STEP);
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: registered PC, redirect priority, flush pulse,
// halt state and saturating fetch counter.
module pc_unit
  import samba_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int unsigned PC_STEP   = 1,
  parameter int unsigned RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  jump_target_i,
  input  logic                 halt_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic [PC_WIDTH-1:0]  pc_next_o,
  output logic                 valid_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

  localparam logic [PC_WIDTH-1:0] RESET_VAL = PC_WIDTH'(RESET_PC);

  pc_state_t             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  flush_q, flush_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  advance;

  pc_adder #(
    .PC_WIDTH (PC_WIDTH),
    .PC_STEP  (PC_STEP)
  ) u_adder (
    .pc  (pc_q),
    .sum (pc_next_o)
  );

  // State and pipeline-facing registers; synchronous reset restores everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VAL;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state / next-PC selection: halt > jump > branch > stall > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      RUN: begin
        valid_d = 1'b1;
        if (halt_i) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (jump_i) begin
          pc_d    = jump_target_i;
          flush_d = 1'b1;
          advance = 1'b1;
        end else if (branch_i) begin
          pc_d    = branch_target_i;
          flush_d = 1'b1;
          advance = 1'b1;
        end else if (!stall_i) begin
          pc_d    = pc_next_o;
          advance = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
    endcase
    if (advance && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign pc_o        = pc_q;
  assign valid_o     = valid_q;
  assign flush_o     = flush_q;
  assign halted_o    = (state_q == HALTED);
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes expectations, monitor checks.
module tb_pc_unit;

  typedef struct {
    logic [8:0]  pc;
    logic        valid;
    logic        flush;
    logic        halt;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults (9-bit, step 1, reset 0, 16-bit counter).
  logic        reset, stall, branch, jump, halt;
  logic [8:0]  btgt, jtgt;
  logic [8:0]  pc, pc_next;
  logic        valid, flush, halted;
  logic [15:0] cnt;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall), .branch_i(branch),
    .branch_target_i(btgt), .jump_i(jump), .jump_target_i(jtgt),
    .halt_i(halt), .pc_o(pc), .pc_next_o(pc_next), .valid_o(valid),
    .flush_o(flush), .halted_o(halted), .fetch_cnt_o(cnt)
  );

  // Second instance: step 4, reset PC 505, 2-bit counter.
  logic        reset2;
  logic        zero1 = 1'b0;
  logic [8:0]  zero9 = '0;
  logic [8:0]  pc2, pc_next2;
  logic        valid2, flush2, halted2;
  logic [1:0]  cnt2;

  pc_unit #(
    .PC_WIDTH(9), .PC_STEP(4), .RESET_PC(505), .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .stall_i(zero1), .branch_i(zero1),
    .branch_target_i(zero9), .jump_i(zero1), .jump_target_i(zero9),
    .halt_i(zero1), .pc_o(pc2), .pc_next_o(pc_next2), .valid_o(valid2),
    .flush_o(flush2), .halted_o(halted2), .fetch_cnt_o(cnt2)
  );

  exp_t q1[$];
  exp_t q2[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
  endtask

  // Monitor: one expectation is consumed per clock after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("pc_next", 32'(pc_next), 32'((e.pc + 9'd1) % 512));
        chk("valid", 32'(valid), 32'(e.valid));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("halted", 32'(halted), 32'(e.halt));
        chk("fetch_cnt", 32'(cnt), 32'(e.cnt));
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("pc2", 32'(pc2), 32'(e.pc));
        chk("pc_next2", 32'(pc_next2), 32'((32'(e.pc) + 4) % 512));
        chk("valid2", 32'(valid2), 32'(e.valid));
        chk("flush2", 32'(flush2), 32'(e.flush));
        chk("halted2", 32'(halted2), 32'(e.halt));
        chk("fetch_cnt2", 32'(cnt2), 32'(e.cnt));
      end
    end
  end

  // Drive one cycle of controls and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic h, input logic j, input logic [8:0] jt,
                      input logic b, input logic [8:0] bt, input logic s,
                      input logic [8:0] e_pc, input logic e_v, input logic e_f,
                      input logic e_h, input logic [15:0] e_c);
    exp_t e;
    @(negedge clk);
    reset = r; halt = h; jump = j; jtgt = jt; branch = b; btgt = bt; stall = s;
    e.pc = e_pc; e.valid = e_v; e.flush = e_f; e.halt = e_h; e.cnt = e_c;
    q1.push_back(e);
  endtask

  task automatic step2(input logic r, input logic [8:0] e_pc, input logic e_v,
                       input logic [15:0] e_c);
    exp_t e;
    @(negedge clk);
    reset2 = r;
    e.pc = e_pc; e.valid = e_v; e.flush = 1'b0; e.halt = 1'b0; e.cnt = e_c;
    q2.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    stall = 1'b0; branch = 1'b0; jump = 1'b0; halt = 1'b0;
    btgt = '0; jtgt = '0;
    //    r  h  j  jt    b  bt    s   pc   v  f  h  cnt
    step(1, 0, 0, 0,    0, 0,    0,  0,   0, 0, 0, 0);
    step(1, 0, 0, 0,    0, 0,    0,  0,   0, 0, 0, 0);
    // free run
    step(0, 0, 0, 0,    0, 0,    0,  1,   1, 0, 0, 1);
    step(0, 0, 0, 0,    0, 0,    0,  2,   1, 0, 0, 2);
    step(0, 0, 0, 0,    0, 0,    0,  3,   1, 0, 0, 3);
    step(0, 0, 0, 0,    0, 0,    0,  4,   1, 0, 0, 4);
    step(0, 0, 0, 0,    0, 0,    0,  5,   1, 0, 0, 5);
    // stall at 10
    step(0, 0, 1, 10,   0, 0,    0,  10,  1, 1, 0, 6);
    step(0, 0, 0, 0,    0, 0,    1,  10,  1, 0, 0, 6);
    step(0, 0, 0, 0,    0, 0,    1,  10,  1, 0, 0, 6);
    step(0, 0, 0, 0,    0, 0,    1,  10,  1, 0, 0, 6);
    step(0, 0, 0, 0,    0, 0,    0,  11,  1, 0, 0, 7);
    // back-to-back redirects, branch beats stall, jump beats branch
    step(0, 0, 1, 20,   0, 0,    0,  20,  1, 1, 0, 8);
    step(0, 0, 0, 0,    1, 100,  1,  100, 1, 1, 0, 9);
    step(0, 0, 1, 7,    1, 50,   0,  7,   1, 1, 0, 10);
    step(0, 0, 0, 0,    0, 0,    0,  8,   1, 0, 0, 11);
    // wrap at max PC
    step(0, 0, 1, 511,  0, 0,    0,  511, 1, 1, 0, 12);
    step(0, 0, 0, 0,    0, 0,    0,  0,   1, 0, 0, 13);
    step(0, 0, 0, 0,    0, 0,    0,  1,   1, 0, 0, 14);
    // halt at 42, redirects ignored
    step(0, 0, 1, 42,   0, 0,    0,  42,  1, 1, 0, 15);
    step(0, 1, 0, 0,    0, 0,    0,  42,  0, 0, 1, 15);
    step(0, 0, 1, 300,  1, 200,  0,  42,  0, 0, 1, 15);
    step(0, 1, 0, 0,    1, 9,    1,  42,  0, 0, 1, 15);
    step(1, 0, 0, 0,    0, 0,    0,  0,   0, 0, 0, 0);
    step(0, 0, 0, 0,    0, 0,    0,  1,   1, 0, 0, 1);
    // halt wins over a same-cycle jump
    step(0, 1, 1, 77,   0, 0,    0,  1,   0, 0, 1, 1);
    step(1, 0, 0, 0,    0, 0,    0,  0,   0, 0, 0, 0);
    step(0, 0, 0, 0,    0, 0,    0,  1,   1, 0, 0, 1);
    // reset while flush is high, with a redirect in flight
    step(0, 0, 0, 0,    1, 300,  0,  300, 1, 1, 0, 2);
    step(1, 0, 1, 99,   0, 0,    0,  0,   0, 0, 0, 0);
    step(0, 0, 0, 0,    0, 0,    0,  1,   1, 0, 0, 1);

    // second instance: step 4 wrap (509+4 -> 1) and 2-bit counter saturation
    step2(1, 505, 0, 0);
    step2(0, 509, 1, 1);
    step2(0, 1,   1, 2);
    step2(0, 5,   1, 3);
    step2(0, 9,   1, 3);
    step2(0, 13,  1, 3);
    step2(0, 17,  1, 3);

    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", 32'(q1.size() + q2.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
